sram_like_rr_arbiter: RTL and testbench



---
 rtl/sram_like_pkg.sv | 14 +
 rtl/sram_like_rr_arbiter_if.sv | 45 ++++
 rtl/sram_like_id_fifo.sv | 59 +++++
 rtl/sram_like_rr_arbiter.sv | 109 ++++++++++
 tb/tb_sram_like_rr_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sram_like_pkg.sv
// Shared constants and helpers for the SRAM-like bus blocks.
package sram_like_pkg;

  // Transfer size encoding on the size field
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Bits needed to name one of n channels; never narrower than 1 bit
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_like_rr_arbiter_if.sv
// Bundle of the per-master SRAM-like ports and the single slave port.
interface sram_like_rr_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // master side, channel i in row i
  logic [NUM_CH-1:0]             m_req;
  logic [NUM_CH-1:0]             m_wr;
  logic [NUM_CH-1:0][1:0]        m_size;
  logic [NUM_CH-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_CH-1:0]             m_addr_ok;
  logic [NUM_CH-1:0]             m_data_ok;
  logic [DATA_W-1:0]             m_rdata;
  // slave side
  logic                          s_req;
  logic                          s_wr;
  logic [1:0]                    s_size;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic                          s_addr_ok;
  logic                          s_data_ok;
  logic [DATA_W-1:0]             s_rdata;

  // the arbiter itself
  modport arb (
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  // the requesting masters
  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  // the downstream memory / converter
  modport slave (
    input  s_req, s_wr, s_size, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );
endinterface

// File: rtl/sram_like_id_fifo.sv
// Small synchronous FIFO holding channel IDs of accepted requests.
// Push while full and pop while empty are ignored.
module sram_like_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_din,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wp;
  logic [PW-1:0]           r_rp;
  logic [CW-1:0]           r_cnt;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // pointer / occupancy update; simultaneous push+pop keeps the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // storage; contents need no reset, occupancy guards reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/sram_like_rr_arbiter.sv
// Round-robin merge of NUM_CH SRAM-like masters onto one slave port.
// Accepted requests queue their channel ID so in-order responses are
// steered back to the issuing master.
module sram_like_rr_arbiter
  import sram_like_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  sram_like_rr_arbiter_if.arb                bus,
  output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt,
  output logic                               err_unexp
);
  localparam int IDW = id_w(NUM_CH);
  localparam int CW  = $clog2(MAX_OUTST+1);

  logic [IDW-1:0] r_rr_ptr;
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;
  logic           r_err;

  logic [IDW-1:0] w_scan;
  logic           w_found;
  logic [IDW-1:0] w_gnt;
  logic           w_gnt_vld;
  logic           w_acc;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [IDW-1:0] w_head;
  logic [CW-1:0]  w_cnt;

  // first requester at or after rr_ptr, wrapping at NUM_CH
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_scan  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!w_found && bus.m_req[idx]) begin
        w_found = 1'b1;
        w_scan  = IDW'(idx);
      end
    end
  end

  // a pending, unaccepted request keeps its grant so the slave sees stable fields
  assign w_gnt     = r_lock ? r_lock_id : w_scan;
  assign w_gnt_vld = r_lock | w_found;

  assign bus.s_req   = ~rst & (|bus.m_req) & ~w_full;
  assign bus.s_wr    = w_gnt_vld ? bus.m_wr[w_gnt]    : 1'b0;
  assign bus.s_size  = w_gnt_vld ? bus.m_size[w_gnt]  : SIZE_BYTE;
  assign bus.s_addr  = w_gnt_vld ? bus.m_addr[w_gnt]  : '0;
  assign bus.s_wdata = w_gnt_vld ? bus.m_wdata[w_gnt] : '0;

  assign w_acc = bus.s_req & bus.s_addr_ok;
  assign w_pop = ~rst & bus.s_data_ok & ~w_empty;

  assign bus.m_addr_ok = w_acc ? (NUM_CH'(1) << w_gnt)  : '0;
  assign bus.m_data_ok = w_pop ? (NUM_CH'(1) << w_head) : '0;
  assign bus.m_rdata   = bus.s_rdata;

  assign outst_cnt = rst ? '0 : w_cnt;
  assign err_unexp = r_err;

  sram_like_id_fifo #(.DEPTH(MAX_OUTST), .W(IDW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_acc),
    .i_din   (w_gnt),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  // lock on a stalled request, advance round-robin pointer on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (bus.s_req && !bus.s_addr_ok) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_gnt;
    end else if (w_acc) begin
      r_lock   <= 1'b0;
      r_rr_ptr <= (w_gnt == IDW'(NUM_CH-1)) ? '0 : w_gnt + 1'b1;
    end
  end

  // sticky flag for a response with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst)                         r_err <= 1'b0;
    else if (bus.s_data_ok && w_empty) r_err <= 1'b1;
  end

  // a locked master must keep requesting until it sees addr_ok
  a_lock_hold: assert property (@(posedge clk) disable iff (rst)
    r_lock |-> bus.m_req[r_lock_id]);
endmodule

// File: tb/tb_sram_like_rr_arbiter.sv
// Self-checking bench: fairness table plus lock/full/unexpected/reset sequences.
module tb_sram_like_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cnt;
  logic       err;
  int         n_chk = 0;
  int         n_err = 0;
  logic       sb[$];

  always #5 clk = ~clk;

  sram_like_rr_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus();

  sram_like_rr_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .outst_cnt (cnt),
    .err_unexp (err)
  );

  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic        e_sreq;
    logic [31:0] e_addr;
    logic [1:0]  e_aok;
    logic [1:0]  e_dok;
    logic [1:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t fair[6];

  function automatic logic [31:0] rdata_of(input logic ch);
    return ch ? 32'h0000_00B1 : 32'h0000_00A0;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] a);
    return (a == 32'h1000) ? 32'h11 : (a == 32'h2000) ? 32'h22 : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive one cycle, compare at negedge, scoreboard the responses
  task automatic step(input string nm, input vec_t v);
    logic ch;
    bus.m_req     = v.req;
    bus.s_addr_ok = v.aok;
    bus.s_data_ok = v.dok;
    bus.s_rdata   = (sb.size() > 0) ? rdata_of(sb[0]) : 32'hDEAD_BEEF;
    @(negedge clk);
    chk({nm, ".s_req"},     32'(bus.s_req),     32'(v.e_sreq));
    chk({nm, ".s_addr"},    bus.s_addr,         v.e_addr);
    chk({nm, ".s_wdata"},   bus.s_wdata,        wdata_of(v.e_addr));
    chk({nm, ".m_addr_ok"}, 32'(bus.m_addr_ok), 32'(v.e_aok));
    chk({nm, ".m_data_ok"}, 32'(bus.m_data_ok), 32'(v.e_dok));
    chk({nm, ".outst_cnt"}, 32'(cnt),           32'(v.e_cnt));
    chk({nm, ".err_unexp"}, 32'(err),           32'(v.e_err));
    if (bus.m_data_ok != 2'b00) begin
      if (sb.size() == 0) begin
        chk({nm, ".sb_empty"}, 32'(bus.m_data_ok), 32'h0);
      end else begin
        ch = sb.pop_front();
        chk({nm, ".sb_dok"},   32'(bus.m_data_ok), ch ? 32'h2 : 32'h1);
        chk({nm, ".sb_rdata"}, bus.m_rdata,        rdata_of(ch));
      end
    end
    if (v.e_aok != 2'b00) sb.push_back(v.e_aok[1]);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic aok, input logic dok,
                              input logic e_sreq, input logic [31:0] e_addr,
                              input logic [1:0] e_aok, input logic [1:0] e_dok,
                              input logic [1:0] e_cnt, input logic e_err);
    vec_t v;
    v.req = req; v.aok = aok; v.dok = dok; v.e_sreq = e_sreq; v.e_addr = e_addr;
    v.e_aok = e_aok; v.e_dok = e_dok; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // both masters request; slave answers one cycle after each accept
    fair[0] = mk(2'b11, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 0);
    fair[1] = mk(2'b11, 1, 1, 1, 32'h2000, 2'b10, 2'b01, 2'd1, 0);
    fair[2] = mk(2'b11, 1, 1, 1, 32'h1000, 2'b01, 2'b10, 2'd1, 0);
    fair[3] = mk(2'b11, 1, 1, 1, 32'h2000, 2'b10, 2'b01, 2'd1, 0);
    fair[4] = mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b10, 2'd1, 0);
    fair[5] = mk(2'b00, 0, 0, 0, 32'h0,    2'b00, 2'b00, 2'd0, 0);

    bus.m_wr      = 2'b10;
    bus.m_size[0] = 2'b10;
    bus.m_size[1] = 2'b01;
    bus.m_addr[0] = 32'h1000;
    bus.m_addr[1] = 32'h2000;
    bus.m_wdata[0] = 32'h11;
    bus.m_wdata[1] = 32'h22;
    bus.m_req     = 2'b11;
    bus.s_addr_ok = 1'b1;
    bus.s_data_ok = 1'b0;
    bus.s_rdata   = '0;

    // reset forces handshake outputs low even with requests present
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.s_req",     32'(bus.s_req),     32'h0);
    chk("rst.m_addr_ok", 32'(bus.m_addr_ok), 32'h0);
    chk("rst.outst_cnt", 32'(cnt),           32'h0);
    chk("rst.err_unexp", 32'(err),           32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    step("idle", mk(2'b00, 0, 0, 0, 32'h0, 2'b00, 2'b00, 2'd0, 0));

    for (int i = 0; i < 6; i++) step($sformatf("fair%0d", i), fair[i]);

    // lock: rr_ptr moved to 1, then ch0 stalls while ch1 joins
    step("lk0", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 0));
    step("lk1", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b01, 2'd1, 0));
    step("lk2", mk(2'b01, 0, 0, 1, 32'h1000, 2'b00, 2'b00, 2'd0, 0));
    step("lk3", mk(2'b11, 0, 0, 1, 32'h1000, 2'b00, 2'b00, 2'd0, 0));
    step("lk4", mk(2'b11, 0, 0, 1, 32'h1000, 2'b00, 2'b00, 2'd0, 0));
    step("lk5", mk(2'b11, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 0));
    step("lk6", mk(2'b10, 1, 0, 1, 32'h2000, 2'b10, 2'b00, 2'd1, 0));
    step("lk7", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b01, 2'd2, 0));
    step("lk8", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b10, 2'd1, 0));

    // full: two accepts block further requests, a pop in the full cycle still blocks
    step("fu0", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 0));
    step("fu1", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd1, 0));
    step("fu2", mk(2'b01, 1, 0, 0, 32'h1000, 2'b00, 2'b00, 2'd2, 0));
    step("fu3", mk(2'b01, 1, 1, 0, 32'h1000, 2'b00, 2'b01, 2'd2, 0));
    step("fu4", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd1, 0));
    step("fu5", mk(2'b00, 0, 0, 0, 32'h0,    2'b00, 2'b00, 2'd2, 0));
    step("fu6", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b01, 2'd2, 0));
    step("fu7", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b01, 2'd1, 0));
    step("fu8", mk(2'b00, 0, 0, 0, 32'h0,    2'b00, 2'b00, 2'd0, 0));

    // unexpected response with empty FIFO; flag is sticky
    step("ux0", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b00, 2'd0, 0));
    step("ux1", mk(2'b00, 0, 0, 0, 32'h0,    2'b00, 2'b00, 2'd0, 1));
    step("ux2", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 1));
    step("ux3", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b01, 2'd1, 1));

    // reset with two transactions in flight
    step("mf0", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 1));
    step("mf1", mk(2'b01, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd1, 1));
    rst = 1'b1;
    bus.m_req = 2'b01; bus.s_addr_ok = 1'b1; bus.s_data_ok = 1'b0;
    @(negedge clk);
    chk("mfr.s_req",     32'(bus.s_req),     32'h0);
    chk("mfr.m_addr_ok", 32'(bus.m_addr_ok), 32'h0);
    chk("mfr.outst_cnt", 32'(cnt),           32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step("mf2", mk(2'b00, 0, 0, 0, 32'h0,    2'b00, 2'b00, 2'd0, 0));
    step("mf3", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b00, 2'd0, 0));
    step("mf4", mk(2'b11, 0, 0, 1, 32'h1000, 2'b00, 2'b00, 2'd0, 1));
    step("mf5", mk(2'b11, 1, 0, 1, 32'h1000, 2'b01, 2'b00, 2'd0, 1));
    step("mf6", mk(2'b00, 0, 1, 0, 32'h0,    2'b00, 2'b01, 2'd1, 1));

    chk("sb.drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
